// File: rtl/img_pkg.sv
// Shared definitions for the pixel ROM streaming path:
// mode codes, luma coefficients and scan FSM encoding.
package img_pkg;

  localparam logic [1:0] MODE_GRAY = 2'd0;
  localparam logic [1:0] MODE_INV  = 2'd1;
  localparam logic [1:0] MODE_BIN  = 2'd2;

  // Coefficients sum to 256 so gray is simply the high byte
  localparam logic [7:0] COEF_R = 8'd77;
  localparam logic [7:0] COEF_G = 8'd150;
  localparam logic [7:0] COEF_B = 8'd29;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN
  } state_t;

endpackage

// File: rtl/rgb_to_gray.sv
// Combinational RGB888 to 8-bit pixel conversion
// (gray, inverted gray or thresholded binary).
import img_pkg::*;

module rgb_to_gray #(
  parameter logic [7:0] THRESH = 8'd128
) (
  input  logic [23:0] rgb,
  input  logic [1:0]  mode,
  output logic [7:0]  pixel
);

  logic [15:0] sum;
  logic [7:0]  gray;

  always_comb begin
    sum = 16'(COEF_R) * {8'd0, rgb[23:16]}
        + 16'(COEF_G) * {8'd0, rgb[15:8]}
        + 16'(COEF_B) * {8'd0, rgb[7:0]};
    gray = sum[15:8];
    case (mode)
      MODE_INV: pixel = 8'hFF - gray;
      MODE_BIN: pixel = (gray >= THRESH) ? 8'hFF : 8'h00;
      default:  pixel = gray;
    endcase
  end

endmodule

// File: rtl/rom_gray_streamer.sv
// Scans the pixel ROM once per start and streams converted
// pixels over a valid/ready interface with a last flag.
import img_pkg::*;

module rom_gray_streamer #(
  parameter int         HEIGHT = 30,
  parameter int         WIDTH  = 30,
  parameter int         BPP    = 3,
  parameter int         PIXELS = HEIGHT * WIDTH,
  parameter int         ADDR_W = 10,
  parameter logic [7:0] THRESH = 8'd128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [8*BPP-1:0]  rd_data,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

  state_t              state, state_n;
  logic [1:0]          mode_q, mode_n;
  logic [ADDR_W-1:0]   addr_n;
  logic [7:0]          data_n;
  logic                valid_n, last_n, busy_n, done_n;
  logic                slot_free, is_last;
  logic [7:0]          pixel;

  rgb_to_gray #(
    .THRESH (THRESH)
  ) u_conv (
    .rgb   (rd_data[23:0]),
    .mode  (mode_q),
    .pixel (pixel)
  );

  assign slot_free = !out_valid || out_ready;
  assign is_last   = (rd_addr == LAST_ADDR);

  always_comb begin
    state_n = state;
    mode_n  = mode_q;
    addr_n  = rd_addr;
    data_n  = out_data;
    valid_n = out_valid;
    last_n  = out_last;
    busy_n  = busy;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = SCAN;
          mode_n  = mode;
          addr_n  = '0;
          busy_n  = 1'b1;
        end
      end
      SCAN: begin
        if (slot_free) begin
          data_n  = pixel;
          valid_n = 1'b1;
          last_n  = is_last;
          if (is_last) state_n = DRAIN;
          else         addr_n  = rd_addr + 1'b1;
        end
      end
      DRAIN: begin
        if (out_valid && out_ready) begin
          valid_n = 1'b0;
          last_n  = 1'b0;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mode_q    <= MODE_GRAY;
      rd_addr   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      mode_q    <= mode_n;
      rd_addr   <= addr_n;
      out_data  <= data_n;
      out_valid <= valid_n;
      out_last  <= last_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_rom_gray_streamer.sv
// Scoreboard bench for rom_gray_streamer: ROM model, reference
// pixel model, stall/ordering/done timing checks.
module tb_rom_gray_streamer;

  localparam int PIX = 900;

  logic        clk = 1'b0;
  logic        rst, start, out_ready;
  logic [1:0]  mode;
  logic [9:0]  rd_addr;
  logic [23:0] rd_data;
  logic [7:0]  out_data;
  logic        out_valid, out_last, busy, done;

  logic [23:0] rom [PIX];
  logic [8:0]  sb [$];

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int beats = 0;
  int done_exp = -1;
  int t0, base, dcyc;
  logic rnd = 1'b0;

  logic       pst = 1'b0;
  logic [7:0] pd;
  logic       pl;
  logic [9:0] pa;

  rom_gray_streamer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  assign rd_data = (int'(rd_addr) < PIX) ? rom[rd_addr] : 24'h0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_pix(input logic [23:0] w,
                                         input logic [1:0] m);
    int s, g;
    s = 77 * int'(w[23:16]) + 150 * int'(w[15:8]) + 29 * int'(w[7:0]);
    g = s / 256;
    case (m)
      2'd1:    return 8'(255 - g);
      2'd2:    return (g >= 128) ? 8'hFF : 8'h00;
      default: return 8'(g);
    endcase
  endfunction

  function automatic logic [7:0] cst(input logic [1:0] m, input int i);
    logic [31:0] v;
    case (m)
      2'd1:    v = 32'hB36AE300;
      2'd2:    v = 32'h00FF00FF;
      default: v = 32'h4C951CFF;
    endcase
    return v[31-8*i -: 8];
  endfunction

  task automatic push_frame(input logic [1:0] m, input logic cmode);
    logic [7:0] d;
    for (int i = 0; i < PIX; i++) begin
      d = (i < 4) ? cst(cmode ? m : 2'd0, i) : ref_pix(rom[i], m);
      if (i >= 4 || !cmode) d = ref_pix(rom[i], m);
      sb.push_back({(i == PIX - 1), d});
    end
  endtask

  task automatic go(input logic [1:0] m, input logic cmode);
    @(posedge clk); #1;
    start = 1'b1;
    mode  = m;
    @(posedge clk); #1;
    start = 1'b0;
    t0    = cyc;
    base  = beats;
    push_frame(m, cmode);
  endtask

  task automatic wait_done(output int dc);
    int n;
    n  = 0;
    dc = -1;
    while (n < 4000) begin
      @(negedge clk);
      if (done) break;
      n++;
    end
    if (!done) chk("done_timeout", 0, 1);
    else dc = cyc;
    chk("sb_empty", sb.size(), 0);
    chk("busy_at_done", busy, 0);
    @(negedge clk);
    chk("done_pulse", done, 0);
  endtask

  task automatic wait_beats(input int k);
    int n;
    n = 0;
    while (beats - base < k && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("beat_wait", (beats - base >= k), 1);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rnd) out_ready = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    logic [8:0] e;
    if (rst) begin
      pst      = 1'b0;
      done_exp = -1;
    end else begin
      if (pst) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, pd);
        chk("stall_last", out_last, pl);
        chk("stall_addr", rd_addr, pa);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("extra_beat", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("beat_data", out_data, e[7:0]);
          chk("beat_last", out_last, e[8]);
        end
        beats++;
        if (out_last) done_exp = cyc + 1;
      end
      if (done) begin
        chk("done_time", cyc, done_exp);
        done_exp = -1;
      end
      if (busy) chk("addr_range", (int'(rd_addr) < PIX), 1);
      pst = out_valid && !out_ready;
      pd  = out_data;
      pl  = out_last;
      pa  = rd_addr;
    end
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    mode      = 2'd0;
    out_ready = 1'b0;
    for (int i = 0; i < PIX; i++) rom[i] = 24'($urandom);
    rom[0] = 24'hFF0000;
    rom[1] = 24'h00FF00;
    rom[2] = 24'h0000FF;
    rom[3] = 24'hFFFFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_addr", rd_addr, 0);
    chk("rst_data", out_data, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge clk); #1;
    rst       = 1'b0;
    out_ready = 1'b1;

    // full frames at full rate, known words at addresses 0..3
    for (int m = 0; m < 3; m++) begin
      go(2'(m), 1'b1);
      chk("busy_start", busy, 1);
      wait_done(dcyc);
      chk("frame_len", dcyc - t0, 901);
      chk("beat_count", beats - base, PIX);
    end

    // random backpressure, reserved mode behaves as gray
    rnd = 1'b1;
    go(2'd3, 1'b0);
    wait_done(dcyc);
    chk("beat_count_rnd", beats - base, PIX);
    rnd = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;

    // start and mode change mid-frame are ignored
    go(2'd1, 1'b1);
    wait_beats(10);
    @(posedge clk); #1;
    start = 1'b1;
    mode  = 2'd2;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_mid", busy, 1);
    wait_done(dcyc);
    chk("frame_len_ign", dcyc - t0, 901);

    // reset mid-frame discards the frame, then restart
    rnd = 1'b1;
    go(2'd0, 1'b0);
    wait_beats(400);
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_addr", rd_addr, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    go(2'd2, 1'b0);
    chk("restart_addr", rd_addr, 0);
    wait_done(dcyc);
    chk("beat_count_re", beats - base, PIX);
    rnd = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
